// File: rtl/flappy_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module   : flappy_pixel_renderer
// Brief    : Two-stage pipelined pixel colouriser for pipes, bird and background.
//            Also accumulates a per-frame bird collision flag.
// Revision : 1.0 - initial release
// ============================================================================
module flappy_pixel_renderer #(
    parameter int          NUM_PIPES   = 2,
    parameter int          PIPE_HALF_W = 50,
    parameter int          GAP_H       = 150,
    parameter int          BIRD_HALF   = 10,
    parameter int          FLOOR_Y     = 475,
    parameter logic [11:0] BG_COLOR    = 12'hF00,
    parameter logic [11:0] PIPE_COLOR  = 12'h0F0,
    parameter logic [11:0] BIRD_COLOR  = 12'hFFF,
    parameter logic [11:0] HIT_COLOR   = 12'hFF0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bright,
    input  logic [9:0]                hCount,
    input  logic [9:0]                vCount,
    input  logic [9:0]                BirdX,
    input  logic [9:0]                BirdY,
    input  logic [10*NUM_PIPES-1:0]   PipeX,
    input  logic [10*NUM_PIPES-1:0]   PipeY,
    output logic [11:0]               rgb,
    output logic                      collision,
    output logic                      collision_pulse
);

    localparam logic [10:0] c_PIPE_HALF_W = 11'(PIPE_HALF_W);
    localparam logic [10:0] c_GAP_H       = 11'(GAP_H);
    localparam logic [10:0] c_BIRD_HALF   = 11'(BIRD_HALF);
    localparam logic [10:0] c_FLOOR_Y     = 11'(FLOOR_Y);

    // Lower bound of a centred span, clamped at zero instead of wrapping.
    function automatic logic [10:0] lo_bound(input logic [9:0] c, input logic [10:0] half);
        return ({1'b0, c} >= half) ? ({1'b0, c} - half) : 11'd0;
    endfunction

    logic [10:0] w_h;
    logic [10:0] w_v;
    assign w_h = {1'b0, hCount};
    assign w_v = {1'b0, vCount};

    logic [NUM_PIPES-1:0] w_pipe_vec;

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        logic [9:0]  w_px;
        logic [9:0]  w_py;
        logic [10:0] w_xlo;
        logic [10:0] w_xhi;
        logic [10:0] w_gap_end;
        logic        w_in_x;
        logic        w_in_y;

        assign w_px      = PipeX[10*gi +: 10];
        assign w_py      = PipeY[10*gi +: 10];
        assign w_xlo     = lo_bound(w_px, c_PIPE_HALF_W);
        assign w_xhi     = {1'b0, w_px} + c_PIPE_HALF_W;
        assign w_gap_end = {1'b0, w_py} + c_GAP_H;
        assign w_in_x    = (w_h >= w_xlo) && (w_h <= w_xhi);
        assign w_in_y    = (w_v <= {1'b0, w_py}) || (w_v >= w_gap_end);
        assign w_pipe_vec[gi] = w_in_x && w_in_y;
    end

    logic [10:0] w_bxlo;
    logic [10:0] w_bxhi;
    logic [10:0] w_bylo;
    logic [10:0] w_byhi;
    logic        w_pipe_hit;
    logic        w_bird_hit;
    logic        w_floor_hit;
    logic        w_sof;

    assign w_bxlo      = lo_bound(BirdX, c_BIRD_HALF);
    assign w_bxhi      = {1'b0, BirdX} + c_BIRD_HALF;
    assign w_bylo      = lo_bound(BirdY, c_BIRD_HALF);
    assign w_byhi      = {1'b0, BirdY} + c_BIRD_HALF;
    assign w_pipe_hit  = |w_pipe_vec;
    assign w_bird_hit  = (w_h >= w_bxlo) && (w_h <= w_bxhi) &&
                         (w_v >= w_bylo) && (w_v <= w_byhi);
    assign w_floor_hit = w_bird_hit && (w_v >= c_FLOOR_Y);
    assign w_sof       = (hCount == 10'd0) && (vCount == 10'd0);

    logic r_pipe_hit;
    logic r_bird_hit;
    logic r_floor_hit;
    logic r_bright_d;
    logic r_sof_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_hit  <= 1'b0;
            r_bird_hit  <= 1'b0;
            r_floor_hit <= 1'b0;
            r_bright_d  <= 1'b0;
            r_sof_d     <= 1'b0;
        end else begin
            r_pipe_hit  <= w_pipe_hit;
            r_bird_hit  <= w_bird_hit;
            r_floor_hit <= w_floor_hit;
            r_bright_d  <= bright;
            r_sof_d     <= w_sof;
        end
    end

    logic w_frame_hit;
    logic r_acc;

    // Blanked pixels never count, even when the geometry overlaps.
    assign w_frame_hit = r_bright_d && ((r_bird_hit && r_pipe_hit) || r_floor_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb             <= 12'h000;
            r_acc           <= 1'b0;
            collision       <= 1'b0;
            collision_pulse <= 1'b0;
        end else begin
            if (!r_bright_d)
                rgb <= 12'h000;
            else if (r_pipe_hit)
                rgb <= PIPE_COLOR;
            else if (r_bird_hit)
                rgb <= collision ? HIT_COLOR : BIRD_COLOR;
            else
                rgb <= BG_COLOR;

            // The SOF pixel's own hit is the first contribution to the new frame.
            if (r_sof_d) begin
                collision       <= r_acc;
                collision_pulse <= r_acc && !collision;
                r_acc           <= w_frame_hit;
            end else begin
                collision_pulse <= 1'b0;
                r_acc           <= r_acc | w_frame_hit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flappy_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flappy_pixel_renderer
// Brief    : Directed and randomized pixel streams checked against a pixel-level
//            reference model of flappy_pixel_renderer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flappy_pixel_renderer;

    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          bright;
    logic [9:0]    hCount;
    logic [9:0]    vCount;
    logic [9:0]    BirdX;
    logic [9:0]    BirdY;
    logic [10*NP-1:0] PipeX;
    logic [10*NP-1:0] PipeY;
    logic [11:0]   rgb;
    logic          collision;
    logic          collision_pulse;

    always #5 clk = ~clk;

    flappy_pixel_renderer #(.NUM_PIPES(NP)) dut (
        .clk             (clk),
        .reset           (reset),
        .bright          (bright),
        .hCount          (hCount),
        .vCount          (vCount),
        .BirdX           (BirdX),
        .BirdY           (BirdY),
        .PipeX           (PipeX),
        .PipeY           (PipeY),
        .rgb             (rgb),
        .collision       (collision),
        .collision_pulse (collision_pulse)
    );

    typedef struct {
        int rgb;
        int coll;
        int pulse;
        int lit_rgb;
        int lit_coll;
        int idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_coll = 0;
    int   m_acc  = 0;
    int   pix_idx = 0;
    int   mpx[NP];
    int   mpy[NP];
    int   mbx;
    int   mby;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s pixel=%0d observed=%0h expected=%0h", tag, idx, obs, expv);
        end
    endtask

    task automatic set_geom(input int p0x, input int p0y, input int p1x, input int p1y,
                            input int bx, input int by);
        mpx[0] = p0x; mpy[0] = p0y; mpx[1] = p1x; mpy[1] = p1y;
        mbx = bx; mby = by;
        PipeX = {10'(p1x), 10'(p0x)};
        PipeY = {10'(p1y), 10'(p0y)};
        BirdX = 10'(bx);
        BirdY = 10'(by);
    endtask

    function automatic bit in_span(input int p, input int c, input int half);
        int lo;
        lo = (c - half < 0) ? 0 : c - half;
        return (p >= lo) && (p <= c + half);
    endfunction

    // Drive one pixel, record what the design must show two edges later,
    // and check the pixel driven on the previous cycle.
    task automatic px(input int h, input int v, input int b,
                      input int lit_rgb = -1, input int lit_coll = -1);
        bit   pipe, bird, flr, fh;
        exp_t e;
        pipe = 0;
        for (int i = 0; i < NP; i++)
            if (in_span(h, mpx[i], 50) && (v <= mpy[i] || v >= mpy[i] + 150)) pipe = 1;
        bird = in_span(h, mbx, 10) && in_span(v, mby, 10);
        flr  = bird && (v >= 475);
        fh   = (b != 0) && ((bird && pipe) || flr);
        if (b == 0)       e.rgb = 'h000;
        else if (pipe)    e.rgb = 'h0F0;
        else if (bird)    e.rgb = (m_coll != 0) ? 'hFF0 : 'hFFF;
        else              e.rgb = 'hF00;
        if (h == 0 && v == 0) begin
            e.pulse = (m_acc != 0 && m_coll == 0) ? 1 : 0;
            m_coll  = m_acc;
            m_acc   = fh ? 1 : 0;
        end else begin
            e.pulse = 0;
            if (fh) m_acc = 1;
        end
        e.coll     = m_coll;
        e.lit_rgb  = lit_rgb;
        e.lit_coll = lit_coll;
        e.idx      = pix_idx++;
        q.push_back(e);

        hCount = 10'(h);
        vCount = 10'(v);
        bright = (b != 0);
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("rgb", e.idx, 32'(rgb), 32'(e.rgb));
            chk("collision", e.idx, 32'(collision), 32'(e.coll));
            chk("collision_pulse", e.idx, 32'(collision_pulse), 32'(e.pulse));
            if (e.lit_rgb >= 0)  chk("rgb_directed", e.idx, 32'(rgb), 32'(e.lit_rgb));
            if (e.lit_coll >= 0) chk("collision_directed", e.idx, 32'(collision), 32'(e.lit_coll));
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bright = 1'b0;
        hCount = 10'd5;
        vCount = 10'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", -1, 32'(rgb), 32'h0);
        chk("reset_collision", -1, 32'(collision), 32'h0);
        chk("reset_pulse", -1, 32'(collision_pulse), 32'h0);
        reset = 1'b0;
        q.delete();
        m_coll = 0;
        m_acc  = 0;
    endtask

    function automatic int clamp10(input int x);
        return (x < 0) ? 0 : ((x > 1023) ? 1023 : x);
    endfunction

    initial begin
        set_geom(200, 150, 400, 100, 300, 240);
        do_reset();

        // Blanked pixels after reset stay black with no collision.
        for (int i = 0; i < 6; i++) px(300 + i, 240, 0, 'h000, 0);

        // Basic colours.
        px(0, 0, 1);
        px(300, 240, 1, 'hFFF);
        px(200, 50, 1, 'h0F0);
        px(400, 300, 1, 'h0F0);
        px(300, 100, 1, 'hF00);

        // Bird overlapping pipe 0 for one frame.
        set_geom(200, 150, 400, 100, 205, 60);
        px(0, 0, 1);
        px(205, 60, 1, 'h0F0);
        px(210, 65, 1);
        set_geom(200, 150, 400, 100, 300, 240);
        px(0, 0, 1, -1, 1);
        px(300, 240, 1, 'hFF0, 1);
        px(305, 245, 1, 'hFF0, 1);
        px(0, 0, 1, -1, 0);
        px(300, 240, 1, 'hFFF, 0);

        // Underflow clamp on pipe left edge.
        set_geom(20, 150, 400, 100, 300, 240);
        px(0, 10, 1, 'h0F0);
        px(70, 10, 1, 'h0F0);
        px(71, 10, 1, 'hF00);

        // Overlap during blanking only, then floor contact.
        set_geom(200, 150, 400, 100, 205, 60);
        px(205, 60, 0, 'h000);
        px(0, 0, 1);
        px(205, 60, 0);
        set_geom(200, 150, 400, 100, 300, 470);
        px(0, 0, 1, -1, 0);
        px(300, 475, 1);
        px(300, 480, 1);
        px(0, 0, 1, -1, 1);
        px(300, 200, 1);

        // Mid-frame reset clears the accumulator.
        px(300, 478, 1);
        do_reset();
        px(0, 0, 1, -1, 0);
        px(300, 200, 1);

        // Randomized frames with geometry moving mid-frame.
        for (int f = 0; f < 40; f++) begin
            int p0x, p1x, bx, by;
            p0x = $urandom_range(0, 639);
            p1x = $urandom_range(0, 639);
            bx  = ($urandom_range(0, 1) == 1) ? clamp10(p0x + $urandom_range(0, 120) - 60)
                                              : $urandom_range(0, 639);
            by  = $urandom_range(0, 489);
            set_geom(p0x, $urandom_range(0, 400), p1x, $urandom_range(0, 400), bx, by);
            px(0, 0, $urandom_range(0, 3) != 0);
            for (int k = 0; k < 60; k++) begin
                if (k == 30) begin
                    mbx = clamp10(mbx + $urandom_range(0, 20) - 10);
                    mby = clamp10(mby + $urandom_range(0, 20) - 10);
                    BirdX = 10'(mbx);
                    BirdY = 10'(mby);
                end
                px(clamp10(mbx + $urandom_range(0, 40) - 20),
                   clamp10(mby + $urandom_range(0, 40) - 20),
                   $urandom_range(0, 7) != 0);
            end
        end
        px(0, 0, 1);
        px(5, 5, 0);
        px(5, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flappy_pixel_renderer.md
Name: flappy_pixel_renderer

Overview:
- Parametrised, pipelined successor to the combinational pixel colouriser. Sits between the VGA timing generator and the RGB pins.
- Draws NUM_PIPES pipe pairs and the bird over a background colour.
- Registers all hit tests and output colour.
- Detects bird/pipe and bird/floor overlap per frame and reports a sticky frame-level collision flag to game control.

Parameters:
NUM_PIPES, 2, number of pipe pairs (1..4)
PIPE_HALF_W, 50, pipe half-width in pixels
GAP_H, 150, vertical gap height below pipe top edge
BIRD_HALF, 10, bird half-size (square 2*BIRD_HALF+1)
FLOOR_Y, 475, vCount at/after which bird pixels count as floor collision
BG_COLOR, 12'hF00, background
PIPE_COLOR, 12'h0F0, pipe
BIRD_COLOR, 12'hFFF, bird normal
HIT_COLOR, 12'hFF0, bird while collision flag set

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
bright  in  1  display-active from timing generator
hCount  in  10  current pixel column
vCount  in  10  current pixel row
BirdX  in  10  bird centre X
BirdY  in  10  bird centre Y
PipeX  in  10*NUM_PIPES  pipe centre X; pipe i at bits [10i+9:10i]
PipeY  in  10*NUM_PIPES  pipe i bottom of top segment
rgb  out  12  registered pixel colour
collision  out  1  sticky: previous frame contained a collision pixel
collision_pulse  out  1  one-cycle pulse on collision 0->1

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high.
  - On reset: rgb=0, collision=0, collision_pulse=0, frame accumulator=0, all pipeline registers=0.
- Arithmetic: all bound computations use 11-bit unsigned.
  - Lower bounds (X-HALF, Y-BIRD_HALF) clamp at 0 on underflow.
  - Upper bounds (X+HALF, PipeY+GAP_H) use the 11-bit sum, so no wrap.
  - All comparisons are inclusive.
- Stage 1 (cycle N+1), registers:
  - pipe_hit: OR over i of (hCount in [PipeX_i-PIPE_HALF_W, PipeX_i+PIPE_HALF_W]) and (vCount<=PipeY_i or vCount>=PipeY_i+GAP_H).
  - bird_hit: hCount in [BirdX±BIRD_HALF] and vCount in [BirdY±BIRD_HALF].
  - floor_hit: bird_hit and vCount>=FLOOR_Y.
  - bright_d.
  - sof_d = (hCount==0 and vCount==0).
- Stage 2 (cycle N+2), rgb priority:
  1. ~bright_d -> 0.
  2. pipe_hit -> PIPE_COLOR.
  3. bird_hit -> HIT_COLOR if collision, else BIRD_COLOR.
  4. Otherwise -> BG_COLOR.
- Latency: rgb for input pixel at cycle N appears after the edge ending cycle N+1. Fixed 2-cycle latency; no bubbles.
- Collision accumulation:
  - frame_hit = bright_d and ((bird_hit and pipe_hit) or floor_hit).
  - When sof_d=0: acc <= acc | frame_hit.
  - When sof_d=1: collision <= acc; acc <= frame_hit. The SOF pixel's hit belongs to the new frame.
  - collision changes only on sof_d cycles.
- collision_pulse=1 for exactly the cycle after collision rises 0->1. It is 0 when collision stays 1 or falls.
- Blanking (bright_d=0) never contributes to acc, even if the geometric tests pass.
- Overlapping pipes: OR semantics; no priority between them.
- Reset mid-frame clears acc and collision. Accumulation restarts immediately; the first reported value follows the next SOF.
- Input changes to Bird*/Pipe* mid-frame take effect per pixel; no internal latching.

Test Plan:
1. Reset high 3 cycles, then release with bright=0 -> rgb=0, collision=0, collision_pulse=0 throughout.
2. NUM_PIPES=2, PipeX={400,200}, PipeY={100,150}, BirdX=300, BirdY=240, bright=1; sweep pixel (300,240) -> rgb=12'hFFF two cycles later. Pixels (200,50) and (400,300) -> 12'h0F0. Pixel (300,100) -> 12'hF00.
3. BirdX=205, BirdY=60 overlapping pipe 0 (PipeX=200, PipeY=150); run one full frame then SOF -> collision=1 on the cycle after the SOF pixel's stage 2. collision_pulse high exactly one cycle. Later bird pixels -> 12'hFF0.
4. Next frame with no overlap, then SOF -> collision returns to 0; no pulse.
5. PipeX=20 (underflow clamp): hCount=0, vCount=10 -> rgb=PIPE_COLOR; hCount=71 -> BG_COLOR.
6. Bird overlapping a pipe only during blanking (bright=0) -> collision stays 0. Separately, BirdY=470 (bird reaches FLOOR_Y) with bright=1 -> collision=1 after next SOF.
